trigger_buffer_ctrl: RTL and testbench

//  Buffer controller and trigger unit downstream of the channel blocks.
//  - Consumes each channel's ADC sample stream (adc_data_o/adc_rdy_o).
//  - Drives the shared we / rqst_data / num_samples inputs of the channel RAM controllers.
//  - Runs acquisition: pre-trigger fill, trigger wait, post-trigger fill, hold for readout.
//  - Configured over the simple register bus.

---
 rtl/trigger_buffer_ctrl_pkg.sv | 47 ++++
 rtl/trigger_buffer_ctrl_if.sv | 14 +
 rtl/trigger_buffer_ctrl_trigger_detector.sv | 80 ++++++++
 rtl/trigger_buffer_ctrl.sv | 169 ++++++++++++++++
 tb/tb_trigger_buffer_ctrl.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/trigger_buffer_ctrl_pkg.sv
// Shared definitions for the trigger/buffer controller:
//   register addresses, command and settings bit fields, default register
//   values, FSM state encoding, trigger source encoding.
package trigger_buffer_ctrl_pkg;

   localparam int ADDR_REQUESTS         = 5;
   localparam int ADDR_TRIGGER_SETTINGS = 6;
   localparam int ADDR_TRIGGER_VALUE    = 7;
   localparam int ADDR_NUM_SAMPLES      = 8;
   localparam int ADDR_PRE_TRIGGER      = 9;

   localparam int DEFAULT_TRIGGER_SETTINGS = 0;
   localparam int DEFAULT_TRIGGER_VALUE    = 128;
   localparam int DEFAULT_NUM_SAMPLES      = 128;
   localparam int DEFAULT_PRE_TRIGGER      = 64;

   // TRIGGER_SETTINGS fields
   localparam int TS_EDGE    = 0;
   localparam int TS_SRC_LSB = 1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PRE  = 3'd1,
      S_WAIT = 3'd2,
      S_POST = 3'd3,
      S_DONE = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      SRC_CH1   = 2'd0,
      SRC_CH2   = 2'd1,
      SRC_EXT   = 2'd2,
      SRC_FORCE = 2'd3
   } trig_src_e;

   // REQUESTS word: bit0 START, bit1 ABORT, bit2 READ
   typedef struct packed {
      logic read;
      logic abort;
      logic start;
   } req_t;

   function automatic logic [15:0] min16(input logic [15:0] a, input logic [15:0] b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/trigger_buffer_ctrl_if.sv
// Simple register bus: one-cycle write strobe with address and data.
//   master: drives register_addr / register_data / register_rdy
//   slave : receives them
interface trigger_buffer_ctrl_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
);
   logic [ADDR_W-1:0] register_addr;
   logic [DATA_W-1:0] register_data;
   logic              register_rdy;

   modport master (output register_addr, output register_data, output register_rdy);
   modport slave  (input  register_addr, input  register_data, input  register_rdy);
endinterface

// File: rtl/trigger_buffer_ctrl_trigger_detector.sv
// Trigger detector: selects the trigger source and raises trig_hit for one
// cycle when the armed condition is met.
//   clk, rst     clock, async active-high reset
//   arm          high while the controller waits for a trigger
//   src, falling source select and edge polarity
//   level        comparison level for CH1/CH2
//   ch*_data/rdy channel sample streams
//   ext_trigger  asynchronous external pin
//   trig_hit     trigger event (always coincident with a strobe)
module trigger_buffer_ctrl_trigger_detector
   import trigger_buffer_ctrl_pkg::*;
#(
   parameter int BITS_ADC = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                arm,
   input  trig_src_e           src,
   input  logic                falling,
   input  logic [BITS_ADC-1:0] level,
   input  logic [BITS_ADC-1:0] ch1_data,
   input  logic                ch1_rdy,
   input  logic [BITS_ADC-1:0] ch2_data,
   input  logic                ch2_rdy,
   input  logic                ext_trigger,
   output logic                trig_hit
);

   logic [BITS_ADC-1:0] ch1_prev, ch2_prev;
   logic                ch1_pv, ch2_pv;     // prev-sample valid flags
   logic [2:0]          ext_sync;           // [1:0] synchroniser, [2] edge history
   logic                ext_pend;
   logic                ext_edge;

   function automatic logic lvl_hit(input logic [BITS_ADC-1:0] prev,
                                    input logic [BITS_ADC-1:0] cur,
                                    input logic [BITS_ADC-1:0] lvl,
                                    input logic                fall);
      return fall ? (prev > lvl && cur <= lvl) : (prev < lvl && cur >= lvl);
   endfunction

   assign ext_edge = falling ? (~ext_sync[1] & ext_sync[2]) : (ext_sync[1] & ~ext_sync[2]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ch1_prev <= '0;
         ch2_prev <= '0;
         ch1_pv   <= 1'b0;
         ch2_pv   <= 1'b0;
         ext_sync <= '0;
         ext_pend <= 1'b0;
      end else begin
         ext_sync <= {ext_sync[1:0], ext_trigger};
         if (ch1_rdy) ch1_prev <= ch1_data;
         if (ch2_rdy) ch2_prev <= ch2_data;
         // Valid flags drop whenever not armed so the first armed sample
         // only primes the history and can never trigger.
         if (!arm)         ch1_pv <= 1'b0;
         else if (ch1_rdy) ch1_pv <= 1'b1;
         if (!arm)         ch2_pv <= 1'b0;
         else if (ch2_rdy) ch2_pv <= 1'b1;
         // EXT edge is held until the next capture-timebase strobe.
         if (!arm)          ext_pend <= 1'b0;
         else if (ext_edge) ext_pend <= 1'b1;
         else if (ch1_rdy)  ext_pend <= 1'b0;
      end
   end

   always_comb begin
      trig_hit = 1'b0;
      case (src)
         SRC_CH1:   trig_hit = arm & ch1_rdy & ch1_pv & lvl_hit(ch1_prev, ch1_data, level, falling);
         SRC_CH2:   trig_hit = arm & ch2_rdy & ch2_pv & lvl_hit(ch2_prev, ch2_data, level, falling);
         SRC_EXT:   trig_hit = arm & ch1_rdy & ext_pend;
         SRC_FORCE: trig_hit = arm & ch1_rdy;
         default:   trig_hit = 1'b0;
      endcase
   end

endmodule

// File: rtl/trigger_buffer_ctrl.sv
// Buffer controller / trigger unit: configuration registers, acquisition FSM
// (pre-trigger fill, trigger wait, post-trigger fill, hold) and RAM control.
//   clk, rst          clock, async active-high reset
//   ch1_adc_*         CH1 samples; ch1_adc_rdy is also the capture timebase
//   ch2_adc_*         CH2 samples
//   ext_trigger       asynchronous external trigger
//   reg_bus           register bus (slave)
//   we                RAM write enable (PRE/WAIT/POST)
//   rqst_data         one-cycle readout request
//   num_samples       NUM_SAMPLES register
//   triggered         capture complete
//   busy              capture in progress
module trigger_buffer_ctrl
   import trigger_buffer_ctrl_pkg::*;
#(
   parameter int BITS_ADC       = 8,
   parameter int REG_ADDR_WIDTH = 8,
   parameter int REG_DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [BITS_ADC-1:0]   ch1_adc_data,
   input  logic                  ch1_adc_rdy,
   input  logic [BITS_ADC-1:0]   ch2_adc_data,
   input  logic                  ch2_adc_rdy,
   input  logic                  ext_trigger,
   trigger_buffer_ctrl_if.slave  reg_bus,
   output logic                  we,
   output logic                  rqst_data,
   output logic [15:0]           num_samples,
   output logic                  triggered,
   output logic                  busy
);

   state_e              state;
   logic [15:0]         cnt, pre_len, post_len;
   trig_src_e           trig_src;
   logic                trig_falling;
   logic [BITS_ADC-1:0] trig_level;
   logic [15:0]         num_samples_r, pre_trigger_r;
   logic [15:0]         eff_pre, eff_post;
   req_t                req;
   logic                trig_hit;

   function automatic logic addr_is(input logic [REG_ADDR_WIDTH-1:0] a, input int target);
      return a == REG_ADDR_WIDTH'(target);
   endfunction

   // REQUESTS is a write pulse, never stored.
   always_comb begin
      req = '0;
      if (reg_bus.register_rdy && addr_is(reg_bus.register_addr, ADDR_REQUESTS))
         req = req_t'(reg_bus.register_data[2:0]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         trig_falling  <= DEFAULT_TRIGGER_SETTINGS[TS_EDGE];
         trig_src      <= trig_src_e'(DEFAULT_TRIGGER_SETTINGS[TS_SRC_LSB +: 2]);
         trig_level    <= BITS_ADC'(DEFAULT_TRIGGER_VALUE);
         num_samples_r <= 16'(DEFAULT_NUM_SAMPLES);
         pre_trigger_r <= 16'(DEFAULT_PRE_TRIGGER);
      end else if (reg_bus.register_rdy) begin
         if (addr_is(reg_bus.register_addr, ADDR_TRIGGER_SETTINGS)) begin
            trig_falling <= reg_bus.register_data[TS_EDGE];
            trig_src     <= trig_src_e'(reg_bus.register_data[TS_SRC_LSB +: 2]);
         end
         if (addr_is(reg_bus.register_addr, ADDR_TRIGGER_VALUE))
            trig_level <= reg_bus.register_data[BITS_ADC-1:0];
         if (addr_is(reg_bus.register_addr, ADDR_NUM_SAMPLES))
            num_samples_r <= 16'(reg_bus.register_data);
         if (addr_is(reg_bus.register_addr, ADDR_PRE_TRIGGER))
            pre_trigger_r <= 16'(reg_bus.register_data);
      end
   end

   assign eff_pre     = min16(pre_trigger_r, num_samples_r);
   assign eff_post    = num_samples_r - eff_pre;
   assign num_samples = num_samples_r;
   assign busy        = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);

   trigger_buffer_ctrl_trigger_detector #(.BITS_ADC(BITS_ADC)) u_trig (
      .clk         (clk),
      .rst         (rst),
      .arm         (state == S_WAIT),
      .src         (trig_src),
      .falling     (trig_falling),
      .level       (trig_level),
      .ch1_data    (ch1_adc_data),
      .ch1_rdy     (ch1_adc_rdy),
      .ch2_data    (ch2_adc_data),
      .ch2_rdy     (ch2_adc_rdy),
      .ext_trigger (ext_trigger),
      .trig_hit    (trig_hit)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         pre_len   <= '0;
         post_len  <= '0;
         we        <= 1'b0;
         triggered <= 1'b0;
         rqst_data <= 1'b0;
      end else begin
         rqst_data <= req.read && (state == S_DONE);
         if (req.abort) begin
            state     <= S_IDLE;
            we        <= 1'b0;
            triggered <= 1'b0;
            cnt       <= '0;
         end else begin
            case (state)
               S_IDLE, S_DONE: begin
                  if (req.start) begin
                     pre_len   <= eff_pre;
                     post_len  <= eff_post;
                     cnt       <= '0;
                     triggered <= 1'b0;
                     if (num_samples_r == 16'd0) begin
                        state     <= S_DONE;
                        triggered <= 1'b1;
                     end else begin
                        state <= (eff_pre == 16'd0) ? S_WAIT : S_PRE;
                        we    <= 1'b1;
                     end
                  end
               end
               S_PRE: begin
                  if (ch1_adc_rdy) begin
                     if (cnt == pre_len - 16'd1) state <= S_WAIT;
                     else                        cnt   <= cnt + 16'd1;
                  end
               end
               S_WAIT: begin
                  // The triggering sample was written (we high) and is post sample 1.
                  if (trig_hit) begin
                     if (post_len <= 16'd1) begin
                        state     <= S_DONE;
                        we        <= 1'b0;
                        triggered <= 1'b1;
                     end else begin
                        state <= S_POST;
                        cnt   <= 16'd1;
                     end
                  end
               end
               S_POST: begin
                  if (ch1_adc_rdy) begin
                     if (cnt == post_len - 16'd1) begin
                        state     <= S_DONE;
                        we        <= 1'b0;
                        triggered <= 1'b1;
                     end else begin
                        cnt <= cnt + 16'd1;
                     end
                  end
               end
               default: begin
                  state <= S_IDLE;
                  we    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_trigger_buffer_ctrl.sv
module tb_trigger_buffer_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  ch1_adc_data = '0;
   logic        ch1_adc_rdy  = 1'b0;
   logic [7:0]  ch2_adc_data = '0;
   logic        ch2_adc_rdy  = 1'b0;
   logic        ext_trigger  = 1'b0;
   logic        we, rqst_data, triggered, busy;
   logic [15:0] num_samples;

   int errors = 0;
   int checks = 0;

   trigger_buffer_ctrl_if bus ();

   trigger_buffer_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .ch1_adc_data (ch1_adc_data),
      .ch1_adc_rdy  (ch1_adc_rdy),
      .ch2_adc_data (ch2_adc_data),
      .ch2_adc_rdy  (ch2_adc_rdy),
      .ext_trigger  (ext_trigger),
      .reg_bus      (bus),
      .we           (we),
      .rqst_data    (rqst_data),
      .num_samples  (num_samples),
      .triggered    (triggered),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [15:0] d);
      bus.register_addr = a;
      bus.register_data = d;
      bus.register_rdy  = 1'b1;
      tick();
      bus.register_rdy  = 1'b0;
   endtask

   task automatic ch1(input logic [7:0] d);
      ch1_adc_data = d;
      ch1_adc_rdy  = 1'b1;
      tick();
      ch1_adc_rdy  = 1'b0;
   endtask

   task automatic ch2(input logic [7:0] d);
      ch2_adc_data = d;
      ch2_adc_rdy  = 1'b1;
      tick();
      ch2_adc_rdy  = 1'b0;
   endtask

   // Compact status probe: {we, triggered, busy}
   task automatic chk(input string name, input logic [2:0] exp);
      checks++;
      if ({we, triggered, busy} !== exp) begin
         errors++;
         $display("FAIL %s: {we,triggered,busy} got %b expected %b", name, {we, triggered, busy}, exp);
      end
   endtask

   task automatic test_reset();
      checks++;
      if ({we, rqst_data, triggered, busy} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected 0000", {we, rqst_data, triggered, busy});
      end
      checks++;
      if (num_samples !== 16'd128) begin
         errors++;
         $display("FAIL reset_num_samples: got %0d expected 128", num_samples);
      end
   endtask

   task automatic test_ch1_rising();
      wr(8, 8); wr(9, 4); wr(7, 128); wr(6, 0);
      wr(5, 1);
      chk("ch1_start", 3'b101);
      ch1(90); ch1(95); ch1(100); ch1(105);   // PRE
      chk("ch1_pre_done", 3'b101);
      ch1(130);                               // first WAIT sample: must not trigger
      ch1(120);
      ch1(130);                               // 120->130 hit, post sample 1
      chk("ch1_after_hit", 3'b101);
      ch1(140);
      ch1(150);
      chk("ch1_post3", 3'b101);
      ch1(160);
      chk("ch1_done", 3'b010);
   endtask

   task automatic test_ch2_falling();
      wr(6, 3); wr(7, 50); wr(9, 0);
      wr(5, 1);
      chk("ch2_start_from_done", 3'b101);
      ch1(10); ch1(200);                      // CH1 activity must not trigger CH2 source
      ch2(60); ch2(55); ch2(45);
      for (int i = 0; i < 6; i++) ch1(0);
      chk("ch2_post7", 3'b101);
      ch1(0);
      chk("ch2_done", 3'b010);
   endtask

   task automatic test_ext_force();
      wr(6, 4); wr(8, 2); wr(9, 0);
      wr(5, 1);
      chk("ext_wait", 3'b101);
      #2 ext_trigger = 1'b1;
      tick(); tick();
      ch1(0);                                 // pending not yet set: no hit
      chk("ext_too_early", 3'b101);
      ch1(0);                                 // consumes the EXT hit
      chk("ext_hit", 3'b101);
      ch1(0);
      chk("ext_done", 3'b010);
      ext_trigger = 1'b0;
      wr(6, 6);
      wr(5, 1);
      ch1(0);
      chk("force_first_rdy", 3'b101);
      ch1(0);
      chk("force_done", 3'b010);
   endtask

   task automatic test_abort_read();
      wr(8, 4);
      wr(5, 1);
      ch1(0);                                 // FORCE -> POST
      wr(5, 2);
      chk("abort_post", 3'b000);
      wr(5, 4);
      checks++;
      if (rqst_data !== 1'b0) begin errors++; $display("FAIL read_in_idle: got %b expected 0", rqst_data); end
      wr(8, 0);
      wr(5, 1);
      chk("num0_done", 3'b010);
      wr(5, 4);
      checks++;
      if (rqst_data !== 1'b1) begin errors++; $display("FAIL read_pulse: got %b expected 1", rqst_data); end
      chk("read_stays_done", 3'b010);
      tick();
      checks++;
      if (rqst_data !== 1'b0) begin errors++; $display("FAIL read_pulse_width: got %b expected 0", rqst_data); end
      wr(5, 3);                               // ABORT beats START
      chk("abort_beats_start", 3'b000);
   endtask

   task automatic test_clamp();
      wr(9, 200); wr(8, 100); wr(6, 6);
      checks++;
      if (num_samples !== 16'd100) begin errors++; $display("FAIL num_samples_reg: got %0d expected 100", num_samples); end
      wr(5, 1);
      for (int i = 0; i < 100; i++) ch1(8'(i));
      chk("clamp_pre_full", 3'b101);
      ch1(0);                                 // FORCE hit with post=0
      chk("clamp_done", 3'b010);
      wr(8, 0);
      wr(5, 1);
      chk("num0_no_we", 3'b010);
   endtask

   task automatic test_reset_mid();
      wr(8, 8); wr(9, 4); wr(6, 0);
      wr(5, 1);
      ch1(1); ch1(2);
      chk("mid_capture", 3'b101);
      #2 rst = 1'b1;
      #1;
      chk("async_reset", 3'b000);
      checks++;
      if (num_samples !== 16'd128) begin errors++; $display("FAIL reset_regs: got %0d expected 128", num_samples); end
      tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      bus.register_addr = '0;
      bus.register_data = '0;
      bus.register_rdy  = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();
      test_reset();
      test_ch1_rising();
      test_ch2_falling();
      test_ext_force();
      test_abort_read();
      test_clamp();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
